// File: rtl/tcp_vlg_ack_ka_ctl.sv
// tcp_vlg_ack_ka_ctl
//   Forced-ACK and keep-alive request generator for one TCP connection,
//   sitting upstream of the TCP TX arbiter.
//
//   A forced ACK is requested when the locally accepted sequence runs ahead
//   of the last reported ACK, either by FORCE_ACK_BYTES or more bytes, or for
//   ACK_TIMEOUT cycles. Keep-alive probes are requested after KA_INTERVAL
//   cycles of remote silence. Once KA_MAX_PROBES probes go unanswered and
//   another interval expires, the connection is declared dead.
//
// Ports
//   clk, rst     clock, synchronous active-high reset
//   connected    connection is in the connected state; low forces idle
//   loc_ack      current local ACK number
//   last_ack     ACK number last reported by the arbiter
//   rx_act       one-cycle pulse per valid inbound segment
//   send_ack     forced-ACK request level, held until ack_sent
//   ack_sent     one-cycle pulse: forced ACK transmitted
//   send_ka      keep-alive request level, held until ka_sent
//   ka_sent      one-cycle pulse: keep-alive transmitted
//   ka_probes    unanswered probes sent since the last rx_act
//   ka_dead      one-cycle pulse: probe limit exhausted
module tcp_vlg_ack_ka_ctl #(
  parameter int ACK_TIMEOUT     = 16384,
  parameter int FORCE_ACK_BYTES = 4000,
  parameter int KA_INTERVAL     = 125000000,
  parameter int KA_MAX_PROBES   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        connected,
  input  logic [31:0] loc_ack,
  input  logic [31:0] last_ack,
  input  logic        rx_act,
  output logic        send_ack,
  input  logic        ack_sent,
  output logic        send_ka,
  input  logic        ka_sent,
  output logic [3:0]  ka_probes,
  output logic        ka_dead
);

  localparam int AT_W = $clog2(ACK_TIMEOUT);
  localparam int KT_W = $clog2(KA_INTERVAL);

  localparam logic [AT_W-1:0] ACK_LAST    = AT_W'(ACK_TIMEOUT - 1);
  localparam logic [KT_W-1:0] KA_LAST     = KT_W'(KA_INTERVAL - 1);
  localparam logic [31:0]     FORCE_BYTES = 32'(FORCE_ACK_BYTES);
  localparam logic [3:0]      MAX_PROBES  = 4'(KA_MAX_PROBES);

  typedef enum logic [1:0] {A_IDLE, A_WAIT, A_REQ} ack_st_t;
  typedef enum logic [1:0] {K_IDLE, K_COUNT, K_REQ, K_DEAD} ka_st_t;

  ack_st_t         ack_st_q, ack_st_d;
  logic [AT_W-1:0] ack_tmr_q, ack_tmr_d;
  ka_st_t          ka_st_q, ka_st_d;
  logic [KT_W-1:0] ka_tmr_q, ka_tmr_d;
  logic [3:0]      ka_probes_q, ka_probes_d;
  logic            ka_rx_seen_q, ka_rx_seen_d;
  logic            send_ack_q, send_ack_d;
  logic            send_ka_q, send_ka_d;
  logic            ka_dead_q, ka_dead_d;

  // Modular difference: sequence-number wrap needs no special handling.
  logic [31:0] diff;
  logic        pending;

  assign diff    = loc_ack - last_ack;
  assign pending = (diff != 32'd0);

  always_comb begin
    ack_st_d     = ack_st_q;
    ack_tmr_d    = ack_tmr_q;
    ka_st_d      = ka_st_q;
    ka_tmr_d     = ka_tmr_q;
    ka_probes_d  = ka_probes_q;
    ka_rx_seen_d = ka_rx_seen_q;
    ka_dead_d    = 1'b0;

    if (!connected) begin
      ack_st_d     = A_IDLE;
      ack_tmr_d    = '0;
      ka_st_d      = K_IDLE;
      ka_tmr_d     = '0;
      ka_probes_d  = '0;
      ka_rx_seen_d = 1'b0;
    end else begin
      case (ack_st_q)
        A_IDLE: begin
          if (pending) begin
            ack_st_d  = A_WAIT;
            ack_tmr_d = '0;
          end
        end
        A_WAIT: begin
          // A piggybacked ACK clearing pending beats any forcing decision.
          if (!pending) begin
            ack_st_d = A_IDLE;
          end else if (diff >= FORCE_BYTES || ack_tmr_q == ACK_LAST) begin
            ack_st_d = A_REQ;
          end else begin
            ack_tmr_d = ack_tmr_q + AT_W'(1);
          end
        end
        A_REQ: begin
          // Held until the arbiter answers, even if pending clears meanwhile.
          if (ack_sent) ack_st_d = A_IDLE;
        end
        default: ack_st_d = A_IDLE;
      endcase

      case (ka_st_q)
        K_IDLE: begin
          ka_st_d     = K_COUNT;
          ka_tmr_d    = '0;
          ka_probes_d = '0;
        end
        K_COUNT: begin
          // Remote activity wins over a coincident timer expiry.
          if (rx_act) begin
            ka_tmr_d    = '0;
            ka_probes_d = '0;
          end else if (ka_tmr_q == KA_LAST) begin
            if (ka_probes_q == MAX_PROBES) begin
              ka_st_d   = K_DEAD;
              ka_dead_d = 1'b1;
            end else begin
              ka_st_d = K_REQ;
            end
          end else begin
            ka_tmr_d = ka_tmr_q + KT_W'(1);
          end
        end
        K_REQ: begin
          // A probe sent after (or with) remote activity is not counted.
          if (ka_sent) begin
            ka_st_d      = K_COUNT;
            ka_tmr_d     = '0;
            ka_probes_d  = (rx_act || ka_rx_seen_q) ? 4'd0 : ka_probes_q + 4'd1;
            ka_rx_seen_d = 1'b0;
          end else if (rx_act) begin
            ka_tmr_d     = '0;
            ka_probes_d  = '0;
            ka_rx_seen_d = 1'b1;
          end
        end
        K_DEAD: ka_st_d = K_DEAD;
        default: ka_st_d = K_IDLE;
      endcase
    end

    send_ack_d = (ack_st_d == A_REQ);
    send_ka_d  = (ka_st_d == K_REQ);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_st_q     <= A_IDLE;
      ack_tmr_q    <= '0;
      ka_st_q      <= K_IDLE;
      ka_tmr_q     <= '0;
      ka_probes_q  <= '0;
      ka_rx_seen_q <= 1'b0;
      send_ack_q   <= 1'b0;
      send_ka_q    <= 1'b0;
      ka_dead_q    <= 1'b0;
    end else begin
      ack_st_q     <= ack_st_d;
      ack_tmr_q    <= ack_tmr_d;
      ka_st_q      <= ka_st_d;
      ka_tmr_q     <= ka_tmr_d;
      ka_probes_q  <= ka_probes_d;
      ka_rx_seen_q <= ka_rx_seen_d;
      send_ack_q   <= send_ack_d;
      send_ka_q    <= send_ka_d;
      ka_dead_q    <= ka_dead_d;
    end
  end

  assign send_ack  = send_ack_q;
  assign send_ka   = send_ka_q;
  assign ka_probes = ka_probes_q;
  assign ka_dead   = ka_dead_q;

endmodule

// File: tb/tb_tcp_vlg_ack_ka_ctl.sv
// Bench for tcp_vlg_ack_ka_ctl: directed scenarios with literal expectations,
// plus an edge-index based behavioural model compared on every negedge.
module tb_tcp_vlg_ack_ka_ctl;

  localparam int AT = 16;
  localparam int FB = 100;
  localparam int KI = 32;
  localparam int MP = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        connected = 1'b0;
  logic [31:0] loc_ack = 32'd0;
  logic [31:0] last_ack = 32'd0;
  logic        rx_act = 1'b0;
  logic        ack_sent = 1'b0;
  logic        ka_sent = 1'b0;
  logic        send_ack;
  logic        send_ka;
  logic [3:0]  ka_probes;
  logic        ka_dead;

  int total = 0;
  int bad = 0;

  tcp_vlg_ack_ka_ctl #(
    .ACK_TIMEOUT(AT), .FORCE_ACK_BYTES(FB), .KA_INTERVAL(KI), .KA_MAX_PROBES(MP)
  ) dut (
    .clk(clk), .rst(rst), .connected(connected),
    .loc_ack(loc_ack), .last_ack(last_ack), .rx_act(rx_act),
    .send_ack(send_ack), .ack_sent(ack_sent),
    .send_ka(send_ka), .ka_sent(ka_sent),
    .ka_probes(ka_probes), .ka_dead(ka_dead)
  );

  always #5 clk = ~clk;

  // Model: timers are expressed as edge indices of the event that started
  // them; the deadline is reached when the current edge index is that many
  // edges later.
  int mcyc = 0;
  bit m_wait = 0, m_req = 0;
  int m_wstart = 0;
  bit k_on = 0, k_req = 0, k_dead = 0, k_rxr = 0, k_pulse = 0;
  int k_start = 0, k_probes = 0;

  always @(posedge clk) begin
    automatic logic [31:0] d = loc_ack - last_ack;
    automatic bit w = m_wait, r = m_req;
    automatic bit on = k_on, kr = k_req, kd = k_dead, rxr = k_rxr, pl = 0;
    automatic int ws = m_wstart, ks = k_start, kp = k_probes;
    if (rst || !connected) begin
      w = 0; r = 0; on = 0; kr = 0; kd = 0; rxr = 0; kp = 0;
    end else begin
      if (r) begin
        if (ack_sent) r = 0;
      end else if (w) begin
        if (d == 32'd0) w = 0;
        else if (d >= 32'(FB) || (mcyc - ws) == AT) begin w = 0; r = 1; end
      end else if (d != 32'd0) begin
        w = 1; ws = mcyc;
      end

      if (!on) begin
        on = 1; ks = mcyc; kp = 0;
      end else if (kd) begin
      end else if (kr) begin
        if (ka_sent) begin
          kp = (rx_act || rxr) ? 0 : kp + 1;
          ks = mcyc; kr = 0; rxr = 0;
        end else if (rx_act) begin
          kp = 0; rxr = 1;
        end
      end else begin
        if (rx_act) begin
          ks = mcyc; kp = 0;
        end else if ((mcyc - ks) == KI) begin
          if (kp == MP) begin kd = 1; pl = 1; end
          else kr = 1;
        end
      end
    end
    m_wait <= w; m_req <= r; m_wstart <= ws;
    k_on <= on; k_req <= kr; k_dead <= kd; k_rxr <= rxr; k_pulse <= pl;
    k_start <= ks; k_probes <= kp;
    mcyc <= mcyc + 1;
  end

  always @(negedge clk) begin
    if (mcyc > 0) begin
      total++;
      if (send_ack !== m_req || send_ka !== k_req ||
          ka_probes !== 4'(k_probes) || ka_dead !== k_pulse) begin
        bad++;
        $display("FAIL model_cmp cyc=%0d got ack=%b ka=%b probes=%0d dead=%b exp ack=%b ka=%b probes=%0d dead=%b",
                 mcyc, send_ack, send_ka, ka_probes, ka_dead, m_req, k_req, k_probes, k_pulse);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
    end
  endtask

  // which: 0 send_ack, 1 send_ka, 2 ka_dead. n = edges until it was seen high.
  task automatic wait_hi(input int which, input int maxn, output int n);
    bit hit;
    n = 0;
    hit = 0;
    while (!hit && n < maxn) begin
      tick(1);
      n++;
      case (which)
        0: hit = send_ack;
        1: hit = send_ka;
        default: hit = ka_dead;
      endcase
    end
    if (!hit) begin
      total++;
      bad++;
      $display("FAIL wait_timeout which=%0d got=0 exp=1 after=%0d", which, n);
    end
  endtask

  initial begin
    int n;
    tick(3);
    chk("rst_send_ack", send_ack, 0);
    chk("rst_send_ka", send_ka, 0);
    chk("rst_probes", ka_probes, 0);
    chk("rst_dead", ka_dead, 0);

    rst = 0; connected = 1;
    tick(2);

    // Threshold path
    loc_ack = 32'd150;
    tick(1); chk("thr_e1", send_ack, 0);
    tick(1); chk("thr_e2", send_ack, 1);
    ack_sent = 1; tick(1); ack_sent = 0; last_ack = 32'd150;
    chk("thr_sent", send_ack, 0);
    tick(20); chk("thr_idle", send_ack, 0);

    // Timeout path
    loc_ack = 32'd160;
    tick(16); chk("to_e16", send_ack, 0);
    tick(1);  chk("to_e17", send_ack, 1);
    ack_sent = 1; last_ack = 32'd160; tick(1); ack_sent = 0;
    chk("to_sent", send_ack, 0);
    loc_ack = 32'd170;
    tick(8); last_ack = 32'd170;
    tick(20); chk("catchup", send_ack, 0);

    // Just below / at the byte threshold
    loc_ack = 32'd269;
    tick(2); chk("diff99", send_ack, 0);
    last_ack = 32'd269; tick(3);
    loc_ack = 32'd369;
    tick(1); chk("diff100_e1", send_ack, 0);
    tick(1); chk("diff100_e2", send_ack, 1);
    ack_sent = 1; last_ack = 32'd369; tick(1); ack_sent = 0;
    chk("diff100_sent", send_ack, 0);

    // Sequence wrap
    last_ack = 32'hFFFF_FFF0; loc_ack = 32'h0000_0060;
    tick(1); chk("wrap_e1", send_ack, 0);
    tick(1); chk("wrap_e2", send_ack, 1);
    ack_sent = 1; last_ack = 32'h0000_0060; tick(1); ack_sent = 0;
    chk("wrap_sent", send_ack, 0);

    // Keep-alive to death
    connected = 0; tick(1);
    chk("drop1_probes", ka_probes, 0);
    chk("drop1_ka", send_ka, 0);
    connected = 1;
    wait_hi(1, 40, n); chk("ka_first", n, 33);
    for (int i = 1; i <= MP; i++) begin
      tick(2); ka_sent = 1; tick(1); ka_sent = 0;
      chk("ka_probe_cnt", ka_probes, i);
      chk("ka_req_drop", send_ka, 0);
      if (i < MP) begin
        wait_hi(1, 40, n); chk("ka_interval", n, 32);
      end
    end
    wait_hi(2, 40, n); chk("dead_at", n, 32);
    chk("dead_no_ka", send_ka, 0);
    tick(1); chk("dead_one_cycle", ka_dead, 0);
    tick(40); chk("dead_quiet", send_ka, 0);
    chk("dead_probes", ka_probes, 3);
    connected = 0; tick(1);
    chk("drop2_probes", ka_probes, 0);
    connected = 1;

    // Liveness
    tick(32); rx_act = 1; tick(1); rx_act = 0;
    chk("rx_at_expiry", send_ka, 0);
    wait_hi(1, 40, n); chk("rx_restart", n, 32);
    ka_sent = 1; tick(1); ka_sent = 0;
    chk("live_p1", ka_probes, 1);
    wait_hi(1, 40, n); chk("live_int", n, 32);
    rx_act = 1; tick(1); rx_act = 0;
    chk("rx_in_req_probes", ka_probes, 0);
    chk("rx_in_req_held", send_ka, 1);
    tick(3); chk("rx_in_req_held2", send_ka, 1);
    ka_sent = 1; tick(1); ka_sent = 0;
    chk("rx_then_sent_ka", send_ka, 0);
    chk("rx_then_sent_probes", ka_probes, 0);
    wait_hi(1, 40, n); chk("live_int2", n, 32);
    ka_sent = 1; tick(1); ka_sent = 0;
    chk("live_p1b", ka_probes, 1);
    wait_hi(1, 40, n); chk("live_int3", n, 32);
    ka_sent = 1; rx_act = 1; tick(1); ka_sent = 0; rx_act = 0;
    chk("rx_with_sent_probes", ka_probes, 0);

    // Mid-operation drop with both requests held
    loc_ack = 32'd260;
    wait_hi(1, 40, n); chk("both_ka", n, 32);
    chk("both_ack", send_ack, 1);
    connected = 0; tick(1);
    chk("drop3_ack", send_ack, 0);
    chk("drop3_ka", send_ka, 0);
    chk("drop3_probes", ka_probes, 0);
    ack_sent = 1; tick(1); ack_sent = 0; tick(2);
    chk("drop3_ignored", send_ack, 0);

    // ack_sent outside A_REQ is ignored
    connected = 1; ack_sent = 1; tick(1); ack_sent = 0;
    chk("early_sent_e1", send_ack, 0);
    tick(1); chk("early_sent_e2", send_ack, 1);

    rst = 1; tick(2);
    chk("rst2_ack", send_ack, 0);
    chk("rst2_ka", send_ka, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/tcp_vlg_ack_ka_ctl.md
# tcp_vlg_ack_ka_ctl

Upstream of the TCP TX arbiter. Generates the arbiter's forced-ACK (`send_ack`) and keep-alive (`send_ka`) requests for one TCP connection. Forced ACKs fire when the locally accepted sequence runs ahead of the last reported ACK, either by too many bytes or for too long. Keep-alives fire on remote silence, and the block declares the connection dead after a bounded number of unanswered probes.

## Interface

Parameters:
- ACK_TIMEOUT, 16384: cycles an unreported ACK may wait before a forced ACK (≥2).
- FORCE_ACK_BYTES, 4000: unreported byte count that forces an immediate ACK (≥1).
- KA_INTERVAL, 125000000: cycles of remote silence before each keep-alive probe (≥2).
- KA_MAX_PROBES, 8: unanswered probes tolerated before declaring the connection dead (1..15).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- connected  in  1  high while the connection is in the connected state.
- loc_ack  in  32  current local ACK number.
- last_ack  in  32  ACK number actually reported by the arbiter.
- rx_act  in  1  one-cycle pulse per valid inbound segment from the remote.
- send_ack  out  1  forced-ACK request; level, held until `ack_sent`.
- ack_sent  in  1  one-cycle pulse: forced ACK transmitted.
- send_ka  out  1  keep-alive request; level, held until `ka_sent`.
- ka_sent  in  1  one-cycle pulse: keep-alive transmitted.
- ka_probes  out  4  unanswered probes sent since the last `rx_act`.
- ka_dead  out  1  one-cycle pulse: probe limit exhausted.

## Operation

- `diff = loc_ack - last_ack`, 32-bit modular, unsigned; sequence-number wrap is inherent. `pending = (diff != 0)`.
- ACK FSM states: A_IDLE, A_WAIT, A_REQ.
  - A_IDLE: if `pending`, go to A_WAIT and set `ack_tmr <= 0`.
  - A_WAIT: if `!pending` (ACK piggybacked on payload), go to A_IDLE.
  - A_WAIT: else if `diff >= FORCE_ACK_BYTES` or `ack_tmr == ACK_TIMEOUT-1`, go to A_REQ.
  - A_WAIT: otherwise `ack_tmr++`.
  - A_REQ: hold until `ack_sent`, then go to A_IDLE. The request is not withdrawn even if `pending` clears, so no handshake is orphaned.
- KA FSM states: K_IDLE, K_COUNT, K_REQ, K_DEAD.
  - K_IDLE: go to K_COUNT with `ka_tmr <= 0` and `ka_probes <= 0`.
  - K_COUNT: `ka_tmr++`. At `ka_tmr == KA_INTERVAL-1`: if `ka_probes == KA_MAX_PROBES`, go to K_DEAD and pulse `ka_dead`; else go to K_REQ.
  - K_REQ: on `ka_sent`, `ka_probes++`, `ka_tmr <= 0`, go to K_COUNT.
  - K_DEAD: terminal; stays until `connected` drops.
  - In K_COUNT or K_REQ, `rx_act` clears `ka_tmr` and `ka_probes`.
  - In K_REQ, `rx_act` without `ka_sent` keeps the state (request stays held); `ka_sent` then returns to K_COUNT without incrementing probes.
- `send_ack = (state == A_REQ)` and `send_ka = (state == K_REQ)`, both registered. Both may be high together; priority belongs to the arbiter.

## Timing

- Reset, and `connected` sampled low: both FSMs go idle (from K_DEAD too); `send_ack=0`, `send_ka=0`, `ka_dead=0`, `ka_probes=0`, all timers 0, effective next edge.
- Byte-threshold path: `diff >= FORCE_ACK_BYTES` first sampled at edge E from A_IDLE → A_WAIT at E → A_REQ at E+1, so `send_ack` is high after E+1.
- Timeout path: A_WAIT entered at edge E → `send_ack` high after edge E+ACK_TIMEOUT.
- `ack_sent` sampled at edge F → `send_ack` low after F.
- `ka_sent` likewise → `send_ka` low after F.
- Keep-alive: K_COUNT entered (or timer cleared) at edge E with no `rx_act` → `send_ka` high after edge E+KA_INTERVAL.
- Simultaneous events:
  - `rx_act` in the same cycle as KA timer expiry: `rx_act` wins; no probe is sent and the timer clears.
  - `rx_act` together with `ka_sent`: probes clear to 0, not 1.
  - `pending` dropping in the same cycle as the threshold/timeout decision: `!pending` wins, go to A_IDLE.
- `ka_dead`: exactly one cycle, on the K_COUNT→K_DEAD edge.
- `ack_sent` / `ka_sent` outside A_REQ / K_REQ are ignored.

## Test plan

All scenarios use ACK_TIMEOUT=16, FORCE_ACK_BYTES=100, KA_INTERVAL=32, KA_MAX_PROBES=3.

- Threshold: connected, `last_ack=0`, `loc_ack` steps to 150 → `send_ack` high 2 edges later. `ack_sent` pulse → low the next cycle; then `last_ack=150` → FSM stays A_IDLE.
- Timeout: `loc_ack=last_ack+10`, held → `send_ack` rises 17 edges after `loc_ack` changes. Separately, `last_ack` catches up at cycle 8 → `send_ack` never asserts.
- Wrap: `last_ack=32'hFFFF_FFF0`, `loc_ack=32'h0000_0060` (diff 0x70=112) → threshold path, `send_ack` after 2 edges.
- Keep-alive to death: no `rx_act`, each `send_ka` answered with `ka_sent` after 3 cycles → 3 probes (`ka_probes` 1,2,3), then `ka_dead` pulses once after the 4th interval. `send_ka` stays 0 until `connected` toggles.
- Liveness: `rx_act` at cycle 31 of the interval → no probe. `rx_act` while `send_ka` is held → `ka_probes=0`, `send_ka` held until `ka_sent`.
- Mid-operation drop: `send_ack` and `send_ka` both high, `connected` → 0 → both 0 next cycle, `ka_probes=0`, later `ack_sent` ignored.
